adder_arbiter: RTL and testbench

//   Shares one 64-bit adder (sixty_four_bit_adder) between NUM_REQ requesters in the ALU.

---
 rtl/adder_arbiter_pkg.sv | 15 +
 rtl/adder_arbiter_if.sv | 34 +++
 rtl/adder_arbiter_grant.sv | 31 +++
 rtl/sixty_four_bit_adder.sv | 14 +
 rtl/adder_arbiter.sv | 117 +++++++++++
 tb/tb_adder_arbiter.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter shared types and constants.
// Round-robin arbitration enabled by ADDER_ARB_ROUND_ROBIN_EN.
package adder_arb_pkg;

  localparam int DATA_W      = 64;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters and adder_arbiter.
// Master = requesters + consumer, slave = arbiter.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_cin;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_sum;

  modport master (
    output req_valid, req_a, req_b,
    output req_cin, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_cin, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_id, rsp_sum
  );

endinterface

// File: rtl/adder_arbiter_grant.sv
// One-hot grant from a request vector.
// Search starts at ptr and wraps past the last index.
module arb_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id
);

  logic found;

  // first pending request at or after ptr
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        id     = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sixty_four_bit_adder.sv
// Shared ALU 64-bit adder; carry-out is not needed.
// Result wraps modulo 2^64.
module sixty_four_bit_adder
  import adder_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum
);

  assign sum = a + b + {{(DATA_W-1){1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 64-bit adder between NUM_REQ requesters.
// ADDER_ARB_ROUND_ROBIN_EN: round-robin, else fixed priority.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_arbiter_if.slave bus,
  output logic          busy
);

  state_e             state;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               op_cin;
  logic [DATA_W-1:0]  sum_d;
  logic [DATA_W-1:0]  sum_q;
  logic [ID_W-1:0]    id_q;
  logic               rsp_valid_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    ptr;
  logic               any_req;

  assign any_req = |bus.req_valid;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // advance pointer past each granted index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == IDLE && any_req) begin
      if (gnt_id == ID_W'(NUM_REQ - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_id + ID_W'(1);
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  arb_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_grant (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .id  (gnt_id)
  );

  assign bus.req_ready = (state == IDLE) ? gnt : '0;

  sixty_four_bit_adder u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .sum (sum_d)
  );

  // grant/execute/respond sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
      sum_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_cin      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= bus.req_a[DATA_W*gnt_id +: DATA_W];
            op_b   <= bus.req_b[DATA_W*gnt_id +: DATA_W];
            op_cin <= bus.req_cin[gnt_id];
            id_q   <= gnt_id;
            state  <= EXEC;
            busy   <= 1'b1;
          end
        end
        EXEC: begin
          sum_q       <= sum_d;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter.
// Expected policy follows ADDER_ARB_ROUND_ROBIN_EN.
module tb_adder_arbiter;

  logic clk;
  logic rst_n;
  logic busy;

  adder_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  adder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt;
  int n_fail;

  logic [63:0] a_q [4];
  logic [63:0] b_q [4];
  logic        c_q [4];
`ifdef ADDER_ARB_ROUND_ROBIN_EN
  int m_ptr;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[64*i +: 64] = a_q[i];
      bus.req_b[64*i +: 64] = b_q[i];
      bus.req_cin[i]        = c_q[i];
    end
  endtask

  task automatic rand_op(input int i);
    a_q[i] = {$urandom, $urandom};
    b_q[i] = {$urandom, $urandom};
    c_q[i] = 1'($urandom_range(0, 1));
  endtask

  function automatic int exp_winner(input logic [3:0] m);
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++)
      if (m[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
    for (int k = 0; k < 4; k++)
      if (m[k]) return k;
`endif
    return 0;
  endfunction

  task automatic run_txn(input logic [3:0] mask,
                         input int hold);
    int          w;
    logic [3:0]  oh;
    logic [63:0] es;
    bus.req_valid = mask;
    drive_ops();
    #1;
    w  = exp_winner(mask);
    oh = 4'b0001 << w;
    es = a_q[w] + b_q[w] + {63'b0, c_q[w]};
    chk("idle_req_ready", 64'(bus.req_ready), 64'(oh));
    chk("idle_busy", 64'(busy), 64'd0);
    cyc();
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    m_ptr = (w + 1) % 4;
`endif
    rand_op(w);
    drive_ops();
    bus.rsp_ready = (hold == 0);
    chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    chk("resp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("resp_id", 64'(bus.rsp_id), 64'(w));
    chk("resp_sum", bus.rsp_sum, es);
    chk("resp_req_ready", 64'(bus.req_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      cyc();
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_id", 64'(bus.rsp_id), 64'(w));
      chk("hold_sum", bus.rsp_sum, es);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("done_rsp_valid", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    m_ptr = 0;
`endif
    for (int i = 0; i < 4; i++) rand_op(i);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    drive_ops();
    repeat (2) cyc();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_sum", bus.rsp_sum, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    cyc();

    a_q[0] = 64'd3; b_q[0] = 64'd4; c_q[0] = 1'b1;
    run_txn(4'b0001, 0);

    a_q[0] = 64'h8000_0000_0000_0000;
    b_q[0] = 64'h8000_0000_0000_0000;
    c_q[0] = 1'b0;
    run_txn(4'b0001, 0);

    a_q[3] = '1; b_q[3] = '0; c_q[3] = 1'b1;
    run_txn(4'b1000, 0);

    repeat (5) run_txn(4'b1111, 0);

    run_txn(4'b0100, 5);

    bus.req_valid = 4'b0010;
    #1;
    cyc();
    chk("rstexec_busy", 64'(busy), 64'd1);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    cyc();
    rst_n = 1'b1;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    m_ptr = 0;
`endif
    chk("rstexec_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rstexec_busy0", 64'(busy), 64'd0);
    chk("rstexec_sum", bus.rsp_sum, 64'd0);
    chk("rstexec_id", 64'(bus.rsp_id), 64'd0);
    repeat (4) begin
      cyc();
      chk("dropped_no_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("dropped_idle", 64'(busy), 64'd0);
    end

    bus.req_valid = 4'b0110;
    #1;
    chk("withdraw_pre",
        64'(bus.req_ready),
        64'(4'b0001 << exp_winner(4'b0110)));
    bus.req_valid = 4'b0010;
    #1;
    run_txn(4'b0010, 0);
    bus.req_valid = '0;
    repeat (3) begin
      cyc();
      chk("withdraw_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    for (int t = 0; t < 30; t++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_txn(m, $urandom_range(0, 2));
    end

    bus.req_valid = '0;
    repeat (2) begin
      cyc();
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("end_req_ready", 64'(bus.req_ready), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
